// File: rtl/cnn_window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_window_gen_pkg
//  Description : Shared defaults, FSM state encodings and a counter-width
//                helper for the CNN sliding-window generator.
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_window_gen_pkg;

    // Default geometry shared with the CNN core.
    localparam int DEF_CI     = 1;
    localparam int DEF_KX     = 3;
    localparam int DEF_KY     = 3;
    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IW     = 28;
    localparam int DEF_IH     = 28;

    // Frame-tracking FSM encodings.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Width of a counter spanning 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_window_gen_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_line_buf
//  Description : DEPTH-entry delay line built on a circular pointer. dout is
//                the sample written DEPTH strobes ago; each strobe overwrites
//                that slot with din and advances the pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module cnn_line_buf
    import cnn_window_gen_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Oldest entry is read before it is overwritten in the same strobe.
    assign dout = mem[ptr];

    // Circular pointer; only control state is reset, storage is rewritten before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (wr_en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Storage write at the current pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_window_gen
//  Description : Stride-1, no-padding sliding-window generator. Buffers KY-1
//                image rows and emits one packed CI*KY*KX window per valid
//                kernel position, one cycle after the completing pixel.
//                Optional macro CNN_WINDOW_STATUS_EN adds o_frame_done and
//                o_win_cnt status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module cnn_window_gen
    import cnn_window_gen_pkg::*;
#(
    parameter int CI     = DEF_CI,
    parameter int KX     = DEF_KX,
    parameter int KY     = DEF_KY,
    parameter int I_F_BW = DEF_I_F_BW,
    parameter int IW     = DEF_IW,
    parameter int IH     = DEF_IH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_soft_reset,
    input  logic                        i_in_valid,
    input  logic [CI*I_F_BW-1:0]        i_in_pixel,
    output logic                        o_ot_valid,
    output logic [CI*KY*KX*I_F_BW-1:0]  o_ot_fmap
`ifdef CNN_WINDOW_STATUS_EN
    ,
    output logic                        o_frame_done,
    output logic [15:0]                 o_win_cnt
`endif
);

    localparam int PIX_W = CI * I_F_BW;
    localparam int XW    = cnt_width(IW);
    localparam int YW    = cnt_width(IH);
    localparam logic [XW-1:0] X_LAST  = XW'(IW - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IH - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(KX - 1);
    localparam logic [YW-1:0] Y_FILL  = YW'(KY - 2);

    // Soft reset aborts the frame and drops any coincident pixel.
    logic clear;
    logic strobe;
    assign clear  = reset | i_soft_reset;
    assign strobe = i_in_valid & ~clear;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;
    assign x_last = (x == X_LAST);
    assign y_last = (y == Y_LAST);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       in_run;

    // Raster position of the pixel presented on the next strobe.
    always_ff @(posedge clk) begin
        if (clear) begin
            x <= '0;
            y <= '0;
        end else if (strobe) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clear) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next state; RUN covers exactly the rows y >= KY-1.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (strobe) state_next = S_FILL;
            S_FILL: if (strobe && x_last && (y == Y_FILL)) state_next = S_RUN;
            S_RUN:  if (strobe && x_last && y_last) state_next = S_DONE;
            S_DONE: state_next = strobe ? S_FILL : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_run = (state == S_RUN);
`ifdef CNN_WINDOW_STATUS_EN
        o_frame_done = (state == S_DONE);
`endif
    end

    // Line-buffer chain: stage 0 holds the previous row, stage j the row j+1 above.
    logic [PIX_W-1:0] lb_out [KY-1];

    for (genvar j = 0; j < KY - 1; j++) begin : g_line_buf
        logic [PIX_W-1:0] lb_in;
        if (j == 0) begin : g_head
            assign lb_in = i_in_pixel;
        end else begin : g_chain
            assign lb_in = lb_out[j-1];
        end
        cnn_line_buf #(
            .DEPTH (IW),
            .WIDTH (PIX_W)
        ) u_line_buf (
            .clk   (clk),
            .reset (clear),
            .wr_en (strobe),
            .din   (lb_in),
            .dout  (lb_out[j])
        );
    end

    logic [PIX_W-1:0]             win      [KY][KX];
    logic [PIX_W-1:0]             win_next [KY][KX];
    logic [CI*KY*KX*I_F_BW-1:0]   fmap_next;

    // Window after this strobe: shift left, new column from line buffers + pixel.
    always_comb begin
        fmap_next = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                if (kx < KX - 1)      win_next[ky][kx] = win[ky][kx+1];
                else if (ky == KY - 1) win_next[ky][kx] = i_in_pixel;
                else                  win_next[ky][kx] = lb_out[KY-2-ky];
                for (int ci = 0; ci < CI; ci++) begin
                    fmap_next[((ci*KY+ky)*KX+kx)*I_F_BW +: I_F_BW] =
                        win_next[ky][kx][ci*I_F_BW +: I_F_BW];
                end
            end
        end
    end

    // Window register array.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int ky = 0; ky < KY; ky++)
                for (int kx = 0; kx < KX; kx++)
                    win[ky][kx] <= '0;
        end else if (strobe) begin
            win <= win_next;
        end
    end

    logic emit;
    assign emit = strobe && in_run && (x >= X_FIRST);

    // Registered window output; fmap holds between windows.
    always_ff @(posedge clk) begin
        if (clear) begin
            o_ot_valid <= 1'b0;
            o_ot_fmap  <= '0;
        end else begin
            o_ot_valid <= emit;
            if (emit) o_ot_fmap <= fmap_next;
        end
    end

`ifdef CNN_WINDOW_STATUS_EN
    // Windows emitted in the current frame; cleared by the next frame's first pixel.
    always_ff @(posedge clk) begin
        if (clear) begin
            o_win_cnt <= '0;
        end else if (strobe && (x == '0) && (y == '0)) begin
            o_win_cnt <= '0;
        end else if (o_ot_valid) begin
            o_win_cnt <= o_win_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_window_gen
//  Description : Self-checking bench for cnn_window_gen on a 5x4 image with a
//                3x3 kernel. Expected windows come from an image array model.
//                Status checks build only with CNN_WINDOW_STATUS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnn_window_gen;

    localparam int CI = 1;
    localparam int KX = 3;
    localparam int KY = 3;
    localparam int BW = 8;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int FW = CI * KY * KX * BW;
    localparam int NWIN = (IW - KX + 1) * (IH - KY + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          soft_reset;
    logic          in_valid;
    logic [BW-1:0] in_pixel;
    logic          ot_valid;
    logic [FW-1:0] ot_fmap;
`ifdef CNN_WINDOW_STATUS_EN
    logic          frame_done;
    logic [15:0]   win_cnt;
`endif

    cnn_window_gen #(
        .CI(CI), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_soft_reset (soft_reset),
        .i_in_valid   (in_valid),
        .i_in_pixel   (in_pixel),
        .o_ot_valid   (ot_valid),
        .o_ot_fmap    (ot_fmap)
`ifdef CNN_WINDOW_STATUS_EN
        ,
        .o_frame_done (frame_done),
        .o_win_cnt    (win_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] img [IH][IW];
    logic [FW-1:0] obs_fmap [$];
    logic [FW-1:0] exp_fmap [$];
    int            obs_cyc  [$];
    int            exp_cyc  [$];
    int            done_cyc [$];

    // Observe every window strobe together with its cycle number.
    always @(negedge clk) begin
        if (ot_valid === 1'b1) begin
            obs_fmap.push_back(ot_fmap);
            obs_cyc.push_back(cyc);
        end
`ifdef CNN_WINDOW_STATUS_EN
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
`endif
    end

    // Model: window whose bottom-right pixel is (y, x), read straight from the image.
    function automatic logic [FW-1:0] win_of(input int y, input int x);
        logic [FW-1:0] f;
        f = '0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                f[(ky*KX+kx)*BW +: BW] = img[y-KY+1+ky][x-KX+1+kx];
        return f;
    endfunction

    function automatic logic [FW-1:0] pack9(input int v0, input int v1, input int v2,
                                            input int v3, input int v4, input int v5,
                                            input int v6, input int v7, input int v8);
        int v [9];
        logic [FW-1:0] f;
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        f = '0;
        for (int i = 0; i < 9; i++) f[i*BW +: BW] = BW'(v[i]);
        return f;
    endfunction

    task automatic fill_ramp(input int offset);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                img[y][x] = BW'(y * IW + x + offset);
    endtask

    task automatic fill_random();
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                img[y][x] = BW'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [BW-1:0] pix, input int gap);
        if (gap > 0) idle(gap);
        in_valid = 1'b1;
        in_pixel = pix;
        @(posedge clk); #1;
    endtask

    // Stream the first npix pixels of img in raster order, recording expected windows.
    task automatic run_frame(input int maxgap, input int npix);
        int n;
        n = 0;
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x < IW; x++) begin
                if (n < npix) begin
                    send(img[y][x], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
                    if (y >= KY - 1 && x >= KX - 1) begin
                        exp_fmap.push_back(win_of(y, x));
                        exp_cyc.push_back(cyc);
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic clear_queues();
        obs_fmap.delete(); obs_cyc.delete();
        exp_fmap.delete(); exp_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; soft_reset = 1'b0; in_valid = 1'b0; in_pixel = '0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (ot_valid !== 1'b0 || ot_fmap !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b fmap=%h, required valid=0 fmap=0", ot_valid, ot_fmap);
        end
        reset = 1'b0;
        idle(2);
        clear_queues();
    endtask

    task automatic test_single_frame();
        fill_ramp(0);
        run_frame(0, IW * IH);
        idle(4);
        checks++;
        if (obs_fmap.size() != NWIN) begin
            errors++;
            $display("FAIL single_count: got %0d windows, required %0d", obs_fmap.size(), NWIN);
        end
        for (int i = 0; i < exp_fmap.size() && i < obs_fmap.size(); i++) begin
            checks++;
            if (obs_fmap[i] !== exp_fmap[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL single_win[%0d]: got %h @%0d, required %h @%0d",
                         i, obs_fmap[i], obs_cyc[i], exp_fmap[i], exp_cyc[i]);
            end
        end
        if (obs_fmap.size() == NWIN) begin
            checks++;
            if (obs_fmap[0] !== pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)) begin
                errors++;
                $display("FAIL single_first: got %h, required %h", obs_fmap[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            end
            checks++;
            if (obs_fmap[NWIN-1] !== pack9(7, 8, 9, 12, 13, 14, 17, 18, 19)) begin
                errors++;
                $display("FAIL single_last: got %h, required %h", obs_fmap[NWIN-1], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
            end
        end
        clear_queues();
    endtask

    task automatic test_gaps();
        fill_ramp(0);
        run_frame(3, IW * IH);
        idle(4);
        checks++;
        if (obs_fmap.size() != NWIN) begin
            errors++;
            $display("FAIL gaps_count: got %0d windows, required %0d", obs_fmap.size(), NWIN);
        end
        for (int i = 0; i < exp_fmap.size() && i < obs_fmap.size(); i++) begin
            checks++;
            if (obs_fmap[i] !== exp_fmap[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL gaps_win[%0d]: got %h @%0d, required %h @%0d",
                         i, obs_fmap[i], obs_cyc[i], exp_fmap[i], exp_cyc[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        fill_ramp(0);
        run_frame(0, IW * IH);
        fill_ramp(100);
        run_frame(0, IW * IH);
        idle(4);
        checks++;
        if (obs_fmap.size() != 2 * NWIN) begin
            errors++;
            $display("FAIL b2b_count: got %0d windows, required %0d", obs_fmap.size(), 2 * NWIN);
        end
        for (int i = 0; i < exp_fmap.size() && i < obs_fmap.size(); i++) begin
            checks++;
            if (obs_fmap[i] !== exp_fmap[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL b2b_win[%0d]: got %h @%0d, required %h @%0d",
                         i, obs_fmap[i], obs_cyc[i], exp_fmap[i], exp_cyc[i]);
            end
        end
        if (obs_fmap.size() > NWIN) begin
            checks++;
            if (obs_fmap[NWIN] !== pack9(100, 101, 102, 105, 106, 107, 110, 111, 112)) begin
                errors++;
                $display("FAIL b2b_frame2_first: got %h, required %h",
                         obs_fmap[NWIN], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
            end
        end
        clear_queues();
    endtask

    task automatic test_random_image();
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(2, IW * IH);
        end
        idle(4);
        checks++;
        if (obs_fmap.size() != 3 * NWIN) begin
            errors++;
            $display("FAIL random_count: got %0d windows, required %0d", obs_fmap.size(), 3 * NWIN);
        end
        for (int i = 0; i < exp_fmap.size() && i < obs_fmap.size(); i++) begin
            checks++;
            if (obs_fmap[i] !== exp_fmap[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL random_win[%0d]: got %h @%0d, required %h @%0d",
                         i, obs_fmap[i], obs_cyc[i], exp_fmap[i], exp_cyc[i]);
            end
        end
        clear_queues();
    endtask

    // Abort after pixel 13 with the soft reset (use_hard=0) or hard reset (use_hard=1).
    task automatic test_abort(input bit use_hard);
        fill_ramp(0);
        run_frame(0, 14);
        if (use_hard) reset = 1'b1;
        else          soft_reset = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'd14;
        @(posedge clk); #1;
        checks++;
        if (ot_valid !== 1'b0 || ot_fmap !== '0) begin
            errors++;
            $display("FAIL abort%0d_outputs: valid=%b fmap=%h, required valid=0 fmap=0",
                     use_hard, ot_valid, ot_fmap);
        end
        reset = 1'b0;
        soft_reset = 1'b0;
        idle(3);
        fill_random();
        run_frame(1, IW * IH);
        idle(4);
        checks++;
        if (obs_fmap.size() != 2 + NWIN) begin
            errors++;
            $display("FAIL abort%0d_count: got %0d windows, required %0d", use_hard, obs_fmap.size(), 2 + NWIN);
        end
        for (int i = 0; i < exp_fmap.size() && i < obs_fmap.size(); i++) begin
            checks++;
            if (obs_fmap[i] !== exp_fmap[i] || obs_cyc[i] != exp_cyc[i]) begin
                errors++;
                $display("FAIL abort%0d_win[%0d]: got %h @%0d, required %h @%0d",
                         use_hard, i, obs_fmap[i], obs_cyc[i], exp_fmap[i], exp_cyc[i]);
            end
        end
        clear_queues();
    endtask

`ifdef CNN_WINDOW_STATUS_EN
    task automatic test_status();
        int last_cyc;
        fill_ramp(0);
        run_frame(0, IW * IH);
        last_cyc = cyc;
        idle(4);
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL status_done_pulses: got %0d pulses, required 1", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != last_cyc) begin
                errors++;
                $display("FAIL status_done_time: got cycle %0d, required %0d", done_cyc[0], last_cyc);
            end
        end
        checks++;
        if (win_cnt !== 16'(NWIN)) begin
            errors++;
            $display("FAIL status_win_cnt: got %0d, required %0d", win_cnt, NWIN);
        end
        clear_queues();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_random_image();
        test_abort(1'b0);
        test_abort(1'b1);
`ifdef CNN_WINDOW_STATUS_EN
        test_status();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
